sdram_cmd_resp: RTL and testbench

Responder end of the 4-bit command / cmd_sent / reply protocol driven by the command sequencer. Runs SDRAM power-up initialisation and asserts init_comp when done. Then accepts one host command per handshake, drives the SDRAM control pins with JEDEC timing, and pulses reply when the command's timing window closes. Sits between the command sequencer and the SDRAM pads, clocked from the 100 MHz PLL clock.

---
 rtl/sdram_cmd_resp.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_sdram_cmd_resp.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_resp.sv
// sdram_cmd_resp
//   Responder end of the 4-bit cmd / cmd_sent / reply protocol. After reset it
//   runs SDRAM power-up initialisation (cke-low wait, PRE-all, REF, REF, MRS),
//   then raises init_comp_o. After that it accepts one host command per
//   cmd_sent change, drives the SDRAM control pins for one cycle, and pulses
//   reply_o when the command's timing window has elapsed.
//
//   Optional build macro: SDRAM_AUTO_REFRESH_EN. It adds a free-running refresh
//   timer, internal REF commands issued without a reply, and a one-deep slot
//   that holds a host command arriving during an internal refresh.
//
// Ports
//   clk, rst            100 MHz clock, asynchronous active-high reset
//   cmd_i[3:0]          command code (0 NOP,1 ACT,2 READ,3 WRITE,4 PRE,5 REF,6 MRS)
//   cmd_sent_i[1:0]     handshake sequence number; any change = new command
//   bank_i, row_addr_i, col_addr_i   address fields sampled with the command
//   init_comp_o         high once initialisation is finished
//   reply_o             one-cycle completion pulse
//   err_o               sticky: illegal code or overrun
//   cke_o, cs_n_o, ras_n_o, cas_n_o, we_n_o, ba_o, addr_o   SDRAM pins
module sdram_cmd_resp #(
  parameter int          INIT_CYCLES = 20000,
  parameter int          T_RP        = 2,
  parameter int          T_RCD       = 2,
  parameter int          T_RFC       = 7,
  parameter int          T_MRD       = 2,
  parameter int          T_WR        = 2,
  parameter int          CAS_LAT     = 2,
  parameter logic [12:0] MODE_REG    = 13'h020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cmd_i,
  input  logic [1:0]  cmd_sent_i,
  input  logic [1:0]  bank_i,
  input  logic [12:0] row_addr_i,
  input  logic [9:0]  col_addr_i,
  output logic        init_comp_o,
  output logic        reply_o,
  output logic        err_o,
  output logic        cke_o,
  output logic        cs_n_o,
  output logic        ras_n_o,
  output logic        cas_n_o,
  output logic        we_n_o,
  output logic [1:0]  ba_o,
  output logic [12:0] addr_o
);

  function automatic int clamp1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int INIT_C = clamp1(INIT_CYCLES);
  localparam int RP_C   = clamp1(T_RP);
  localparam int RCD_C  = clamp1(T_RCD);
  localparam int RFC_C  = clamp1(T_RFC);
  localparam int MRD_C  = clamp1(T_MRD);
  localparam int WR_C   = clamp1(T_WR);
  localparam int CL_C   = clamp1(CAS_LAT);
  localparam int MAX_W  = max2(max2(max2(INIT_C, RP_C), max2(RCD_C, RFC_C)),
                               max2(max2(MRD_C, WR_C), CL_C));
  localparam int WW     = $clog2(MAX_W + 1);

  localparam logic [WW-1:0] W_ONE  = WW'(1);
  localparam logic [WW-1:0] W_INIT = WW'(INIT_C);
  localparam logic [WW-1:0] W_RP   = WW'(RP_C);
  localparam logic [WW-1:0] W_RCD  = WW'(RCD_C);
  localparam logic [WW-1:0] W_RFC  = WW'(RFC_C);
  localparam logic [WW-1:0] W_MRD  = WW'(MRD_C);
  localparam logic [WW-1:0] W_WR   = WW'(WR_C);
  localparam logic [WW-1:0] W_CL   = WW'(CL_C);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] P_DES = 4'b1111;
  localparam logic [3:0] P_NOP = 4'b0111;
  localparam logic [3:0] P_ACT = 4'b0011;
  localparam logic [3:0] P_RD  = 4'b0101;
  localparam logic [3:0] P_WR  = 4'b0100;
  localparam logic [3:0] P_PRE = 4'b0010;
  localparam logic [3:0] P_REF = 4'b0001;
  localparam logic [3:0] P_MRS = 4'b0000;

  localparam logic [12:0] A_PRE_ALL = 13'h0400;

  typedef enum logic [2:0] {
    S_PWR, S_IPRE, S_IREF1, S_IREF2, S_IMRS, S_IDLE, S_CMD, S_AREF
  } state_t;

  state_t        state_q;
  logic [WW-1:0] wait_q;
  logic [1:0]    seq_last_q;
  logic [3:0]    pins_q;
  logic          cke_q, init_comp_q, reply_q, err_q;
  logic [1:0]    ba_q;
  logic [12:0]   addr_q;

  logic          seq_change, issue;
  logic [3:0]    src_cmd;
  logic [1:0]    src_bank;
  logic [12:0]   src_row;
  logic [9:0]    src_col;

  logic [3:0]    iss_pins;
  logic [1:0]    iss_ba;
  logic [12:0]   iss_addr;
  logic [WW-1:0] iss_wait;
  logic          iss_bad, iss_drv;

  assign seq_change = (cmd_sent_i != seq_last_q);

`ifdef SDRAM_AUTO_REFRESH_EN
  localparam int REF_INTERVAL = 780;
  localparam int RCW          = $clog2(REF_INTERVAL);
  localparam logic [RCW-1:0] REF_MAX = RCW'(REF_INTERVAL - 1);

  logic [RCW-1:0] ref_cnt_q;
  logic           ref_req_q, pend_q;
  logic [3:0]     pend_cmd_q;
  logic [1:0]     pend_bank_q;
  logic [12:0]    pend_row_q;
  logic [9:0]     pend_col_q;

  // The held command is replayed at the end of the internal refresh.
  assign src_cmd  = (state_q == S_AREF) ? pend_cmd_q  : cmd_i;
  assign src_bank = (state_q == S_AREF) ? pend_bank_q : bank_i;
  assign src_row  = (state_q == S_AREF) ? pend_row_q  : row_addr_i;
  assign src_col  = (state_q == S_AREF) ? pend_col_q  : col_addr_i;
  assign issue    = ((state_q == S_IDLE) && seq_change && !ref_req_q) ||
                    ((state_q == S_AREF) && (wait_q == W_ONE) && pend_q);
`else
  assign src_cmd  = cmd_i;
  assign src_bank = bank_i;
  assign src_row  = row_addr_i;
  assign src_col  = col_addr_i;
  assign issue    = (state_q == S_IDLE) && seq_change;
`endif

  // Decode of the command about to be issued: pins, address and wait time.
  always_comb begin
    iss_pins = P_NOP;
    iss_ba   = src_bank;
    iss_addr = '0;
    iss_wait = W_ONE;
    iss_bad  = 1'b0;
    iss_drv  = 1'b1;
    case (src_cmd)
      4'd0: iss_drv = 1'b0;
      4'd1: begin iss_pins = P_ACT; iss_addr = src_row;           iss_wait = W_RCD; end
      4'd2: begin iss_pins = P_RD;  iss_addr = {3'b000, src_col}; iss_wait = W_CL;  end
      4'd3: begin iss_pins = P_WR;  iss_addr = {3'b000, src_col}; iss_wait = W_WR;  end
      4'd4: begin iss_pins = P_PRE; iss_addr = A_PRE_ALL; iss_ba = '0; iss_wait = W_RP; end
      4'd5: begin iss_pins = P_REF; iss_wait = W_RFC; end
      4'd6: begin iss_pins = P_MRS; iss_addr = MODE_REG;  iss_ba = '0; iss_wait = W_MRD; end
      default: begin iss_bad = 1'b1; iss_drv = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PWR;
      wait_q      <= W_INIT;
      seq_last_q  <= '0;
      pins_q      <= P_DES;
      cke_q       <= 1'b0;
      ba_q        <= '0;
      addr_q      <= '0;
      init_comp_q <= 1'b0;
      reply_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef SDRAM_AUTO_REFRESH_EN
      ref_cnt_q   <= '0;
      ref_req_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_cmd_q  <= '0;
      pend_bank_q <= '0;
      pend_row_q  <= '0;
      pend_col_q  <= '0;
`endif
    end else begin
      reply_q <= 1'b0;
      // Commands last one cycle; afterwards the bus idles at NOP once cke is up.
      if (cke_q) pins_q <= P_NOP;

      case (state_q)
        S_PWR: begin
          seq_last_q <= cmd_sent_i;
          // cke rises on the last count; PRE-all follows one cycle later.
          if (wait_q == '0) begin
            pins_q  <= P_PRE;
            ba_q    <= '0;
            addr_q  <= A_PRE_ALL;
            wait_q  <= W_RP;
            state_q <= S_IPRE;
          end else begin
            wait_q <= wait_q - W_ONE;
            if (wait_q == W_ONE) begin
              cke_q  <= 1'b1;
              pins_q <= P_NOP;
            end
          end
        end
        S_IPRE, S_IREF1, S_IREF2, S_IMRS: begin
          // Host changes are swallowed until init completes.
          seq_last_q <= cmd_sent_i;
          if (wait_q != W_ONE) begin
            wait_q <= wait_q - W_ONE;
          end else begin
            // Next init command goes out on the edge the previous window closes.
            case (state_q)
              S_IPRE:  begin pins_q <= P_REF; addr_q <= '0; wait_q <= W_RFC; state_q <= S_IREF1; end
              S_IREF1: begin pins_q <= P_REF; wait_q <= W_RFC; state_q <= S_IREF2; end
              S_IREF2: begin pins_q <= P_MRS; addr_q <= MODE_REG; wait_q <= W_MRD; state_q <= S_IMRS; end
              default: begin init_comp_q <= 1'b1; state_q <= S_IDLE; end
            endcase
          end
        end
        S_IDLE: begin
          if (seq_change) seq_last_q <= cmd_sent_i;
`ifdef SDRAM_AUTO_REFRESH_EN
          if (ref_req_q) begin
            pins_q    <= P_REF;
            ba_q      <= '0;
            addr_q    <= '0;
            wait_q    <= W_RFC;
            state_q   <= S_AREF;
            ref_req_q <= 1'b0;
            if (seq_change) begin
              pend_q      <= 1'b1;
              pend_cmd_q  <= cmd_i;
              pend_bank_q <= bank_i;
              pend_row_q  <= row_addr_i;
              pend_col_q  <= col_addr_i;
            end
          end
`endif
        end
        S_CMD: begin
          // Overrun: record it, drop the new command, keep the current one.
          if (seq_change) begin
            seq_last_q <= cmd_sent_i;
            err_q      <= 1'b1;
          end
          if (wait_q == W_ONE) begin
            reply_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wait_q <= wait_q - W_ONE;
          end
        end
`ifdef SDRAM_AUTO_REFRESH_EN
        S_AREF: begin
          if (wait_q == W_ONE) begin
            // An arrival on this edge is left for S_IDLE to see next cycle.
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
          end else begin
            wait_q <= wait_q - W_ONE;
            if (seq_change) begin
              seq_last_q <= cmd_sent_i;
              if (pend_q) begin
                err_q <= 1'b1;
              end else begin
                pend_q      <= 1'b1;
                pend_cmd_q  <= cmd_i;
                pend_bank_q <= bank_i;
                pend_row_q  <= row_addr_i;
                pend_col_q  <= col_addr_i;
              end
            end
          end
        end
`endif
        default: state_q <= S_PWR;
      endcase

      if (issue) begin
        if (iss_drv) begin
          pins_q <= iss_pins;
          ba_q   <= iss_ba;
          addr_q <= iss_addr;
        end
        if (iss_bad) err_q <= 1'b1;
        wait_q  <= iss_wait;
        state_q <= S_CMD;
      end

`ifdef SDRAM_AUTO_REFRESH_EN
      if (ref_cnt_q == REF_MAX) begin
        ref_cnt_q <= '0;
        ref_req_q <= 1'b1;
      end else begin
        ref_cnt_q <= ref_cnt_q + 1'b1;
      end
`endif
    end
  end

  assign init_comp_o = init_comp_q;
  assign reply_o     = reply_q;
  assign err_o       = err_q;
  assign cke_o       = cke_q;
  assign cs_n_o      = pins_q[3];
  assign ras_n_o     = pins_q[2];
  assign cas_n_o     = pins_q[1];
  assign we_n_o      = pins_q[0];
  assign ba_o        = ba_q;
  assign addr_o      = addr_q;

endmodule

// File: tb/tb_sdram_cmd_resp.sv
// Directed bench for sdram_cmd_resp with a short power-up wait (50 clocks).
// Steps: reset values, init command sequence and spacing, discarded pre-init
// change, ACT, back-to-back READ, REF with overrun, reset mid-REF, illegal code.
module tb_sdram_cmd_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cmd;
  logic [1:0]  cmd_sent;
  logic [1:0]  bank;
  logic [12:0] row_addr;
  logic [9:0]  col_addr;
  logic        init_comp, reply, err, cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] addr;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_cmd_resp #(.INIT_CYCLES(50)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_i      (cmd),
    .cmd_sent_i (cmd_sent),
    .bank_i     (bank),
    .row_addr_i (row_addr),
    .col_addr_i (col_addr),
    .init_comp_o(init_comp),
    .reply_o    (reply),
    .err_o      (err),
    .cke_o      (cke),
    .cs_n_o     (cs_n),
    .ras_n_o    (ras_n),
    .cas_n_o    (cas_n),
    .we_n_o     (we_n),
    .ba_o       (ba),
    .addr_o     (addr)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cke"},   32'(cke), 32'h0);
    check({tag, "_pins"},  32'({cs_n, ras_n, cas_n, we_n}), 32'hF);
    check({tag, "_ba"},    32'(ba), 32'h0);
    check({tag, "_addr"},  32'(addr), 32'h0);
    check({tag, "_init"},  32'(init_comp), 32'h0);
    check({tag, "_reply"}, 32'(reply), 32'h0);
    check({tag, "_err"},   32'(err), 32'h0);
  endtask

  initial begin
    rst = 1'b1; cmd = 4'd0; cmd_sent = 2'd0; bank = 2'd0; row_addr = '0; col_addr = '0;
    tick(3);
    check_reset("reset");
    rst = 1'b0;

    // Power-up: cke rises on edge 50, PRE-all on 51.
    tick(49); check("cke_low_e49", 32'(cke), 32'h0);
    tick(1);  check("cke_high_e50", 32'(cke), 32'h1);
              check("nop_e50", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
    tick(1);  check("ipre_pins", 32'({cs_n, ras_n, cas_n, we_n}), 32'h2);
              check("ipre_a10", 32'(addr[10]), 32'h1);
    cmd_sent = 2'd3;  // change during init: must be discarded
    tick(1);  check("ipre_gap_nop", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
    tick(1);  check("iref1_pins", 32'({cs_n, ras_n, cas_n, we_n}), 32'h1);
    tick(6);  check("iref1_gap_nop", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
    tick(1);  check("iref2_pins", 32'({cs_n, ras_n, cas_n, we_n}), 32'h1);
    tick(7);  check("imrs_pins", 32'({cs_n, ras_n, cas_n, we_n}), 32'h0);
              check("imrs_addr", 32'(addr), 32'h020);
              check("imrs_ba", 32'(ba), 32'h0);
    tick(1);  check("init_low_e68", 32'(init_comp), 32'h0);
    tick(1);  check("init_high_e69", 32'(init_comp), 32'h1);

    // cmd_sent held at 3: nothing may run.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("held_no_reply", 32'(reply), 32'h0);
      check("held_no_cmd", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
    end

    // ACT
    cmd = 4'd1; row_addr = 13'h1A5; bank = 2'd2; cmd_sent = 2'd1;
    tick(1);  check("act_pins", 32'({cs_n, ras_n, cas_n, we_n}), 32'h3);
              check("act_addr", 32'(addr), 32'h1A5);
              check("act_ba", 32'(ba), 32'h2);
              check("act_reply0", 32'(reply), 32'h0);
    tick(1);  check("act_nop", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
              check("act_reply1", 32'(reply), 32'h0);
    tick(1);  check("act_reply", 32'(reply), 32'h1);

    // READ launched in the reply cycle.
    cmd = 4'd2; col_addr = 10'h03F; cmd_sent = 2'd2;
    tick(1);  check("rd_pins", 32'({cs_n, ras_n, cas_n, we_n}), 32'h5);
              check("rd_addr", 32'(addr), 32'h03F);
              check("rd_reply0", 32'(reply), 32'h0);
    tick(1);  check("rd_reply1", 32'(reply), 32'h0);
    tick(1);  check("rd_reply", 32'(reply), 32'h1);
    tick(1);  check("rd_reply_end", 32'(reply), 32'h0);
              check("err_clear", 32'(err), 32'h0);

    // REF with overrun two cycles in.
    cmd = 4'd5; cmd_sent = 2'd3;
    tick(1);  check("ref_pins", 32'({cs_n, ras_n, cas_n, we_n}), 32'h1);
    tick(1);
    cmd = 4'd1; cmd_sent = 2'd0;  // dropped
    tick(1);  check("overrun_err", 32'(err), 32'h1);
    tick(4);  check("ref_reply_early", 32'(reply), 32'h0);
    tick(1);  check("ref_reply", 32'(reply), 32'h1);
    tick(1);  check("ref_reply_end", 32'(reply), 32'h0);
              check("dropped_nop", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
    tick(1);  check("dropped_no_reply", 32'(reply), 32'h0);
              check("dropped_nop2", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
              check("err_sticky", 32'(err), 32'h1);

    // Reset asserted in the middle of a REF window.
    cmd = 4'd5; cmd_sent = 2'd1;
    tick(1);  check("ref2_pins", 32'({cs_n, ras_n, cas_n, we_n}), 32'h1);
    tick(1);
    rst = 1'b1;
    #1;
    check_reset("midref_rst");
    tick(2);
    rst = 1'b0;
    tick(68); check("reinit_low", 32'(init_comp), 32'h0);
    tick(1);  check("reinit_high", 32'(init_comp), 32'h1);
              check("reinit_err", 32'(err), 32'h0);

    // Illegal code.
    cmd = 4'd9; cmd_sent = 2'd2;
    tick(1);  check("ill_err", 32'(err), 32'h1);
              check("ill_pins", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
              check("ill_reply0", 32'(reply), 32'h0);
    tick(1);  check("ill_reply", 32'(reply), 32'h1);
    tick(1);  check("ill_reply_end", 32'(reply), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
